// File: rtl/residue_monitor_pkg.sv
// Shared types and default sizing for the residue convergence monitor.
package residue_monitor_pkg;

    localparam int DEFAULT_NUM_LANES = 4;
    localparam int DEFAULT_RES_W     = 9;
    localparam int DEFAULT_CONV_RUNS = 2;
    localparam int DEFAULT_ITER_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EVAL
    } state_t;

endpackage

// File: rtl/residue_monitor_res_deser.sv
// One lane: LSB-first serial-to-parallel residue register and its magnitude.
module res_deser
    import residue_monitor_pkg::*;
#(
    parameter int RES_W = DEFAULT_RES_W
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic             bit_in,
    output logic [RES_W-1:0] abs_val
);

    logic [RES_W-1:0] sr;

    // Bits enter at the top so that after RES_W shifts bit 0 sits at sr[0].
    // A load starts a fresh frame, so stale bits from an aborted frame are dropped.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= {bit_in, {(RES_W-1){1'b0}}};
        end else if (shift) begin
            sr <= {bit_in, sr[RES_W-1:1]};
        end
    end

    // The most negative value maps onto 2^(RES_W-1), which still fits unsigned.
    assign abs_val = sr[RES_W-1] ? (~sr + RES_W'(1)) : sr;

endmodule

// File: rtl/residue_monitor.sv
// Collects serial residue frames from parallel PE lanes and tracks convergence.
module residue_monitor
    import residue_monitor_pkg::*;
#(
    parameter int NUM_LANES = DEFAULT_NUM_LANES,
    parameter int RES_W     = DEFAULT_RES_W,
    parameter int CONV_RUNS = DEFAULT_CONV_RUNS,
    parameter int ITER_W    = DEFAULT_ITER_W
) (
    input  logic                 clka,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] residue_in,
    input  logic [RES_W-1:0]     threshold,
    input  logic [ITER_W-1:0]    max_iter,
    output logic                 frame_done,
    output logic [RES_W-1:0]     max_abs,
    output logic [ITER_W-1:0]    iter_count,
    output logic                 converged,
    output logic                 timeout
);

    localparam int CNT_W = $clog2(RES_W);
    localparam int RUN_W = $clog2(CONV_RUNS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RES_W - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CONV_RUNS);

    state_t                           state;
    logic [CNT_W-1:0]                 bit_cnt;
    logic [RUN_W-1:0]                 run_cnt;
    logic                             load;
    logic                             shift;
    logic [NUM_LANES-1:0][RES_W-1:0]  lane_abs;
    logic [RES_W-1:0]                 frame_max;
    logic                             pass;
    logic [ITER_W-1:0]                next_iter;
    logic [RUN_W-1:0]                 next_run;

    // A start restarts capture from IDLE or mid-frame, but never during EVAL.
    assign load  = start && (state != ST_EVAL) && !clear;
    assign shift = (state == ST_SHIFT) && !start && !clear;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        res_deser #(
            .RES_W(RES_W)
        ) u_deser (
            .clka    (clka),
            .rst_n   (rst_n),
            .clear   (clear),
            .load    (load),
            .shift   (shift),
            .bit_in  (residue_in[i]),
            .abs_val (lane_abs[i])
        );
    end

    always_comb begin
        frame_max = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_abs[i] > frame_max) begin
                frame_max = lane_abs[i];
            end
        end
        pass      = (frame_max <= threshold);
        next_iter = (&iter_count) ? iter_count : iter_count + 1'b1;
        if (!pass) begin
            next_run = '0;
        end else if (run_cnt == RUN_MAX) begin
            next_run = run_cnt;
        end else begin
            next_run = run_cnt + 1'b1;
        end
    end

    // Convergence takes precedence over timeout when both would fire together.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            frame_done <= 1'b0;
            max_abs    <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
        end else if (clear) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            frame_done <= 1'b0;
            max_abs    <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (start) begin
                        bit_cnt <= CNT_W'(1);
                    end else if (bit_cnt == LAST_BIT) begin
                        state   <= ST_EVAL;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    state      <= ST_IDLE;
                    frame_done <= 1'b1;
                    max_abs    <= frame_max;
                    iter_count <= next_iter;
                    run_cnt    <= next_run;
                    if (!converged && !timeout) begin
                        if (next_run == RUN_MAX) begin
                            converged <= 1'b1;
                        end else if ((max_iter != '0) && (next_iter == max_iter)) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_residue_monitor.sv
// Self-checking bench for residue_monitor: vector table, corner sequences, random frames.
module tb_residue_monitor;

    logic        clka;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [3:0]  residue_in;
    logic [8:0]  threshold;
    logic [15:0] max_iter;
    logic        frame_done;
    logic [8:0]  max_abs;
    logic [15:0] iter_count;
    logic        converged;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers.
    int m_iter = 0;
    int m_run  = 0;
    int m_conv = 0;
    int m_tout = 0;
    int m_max  = 0;

    typedef struct {
        int l0;
        int l1;
        int l2;
        int l3;
        int thr;
        int exp_max;
    } vec_t;

    vec_t vecs[6];

    residue_monitor dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .clear      (clear),
        .start      (start),
        .residue_in (residue_in),
        .threshold  (threshold),
        .max_iter   (max_iter),
        .frame_done (frame_done),
        .max_abs    (max_abs),
        .iter_count (iter_count),
        .converged  (converged),
        .timeout    (timeout)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic resetModel();
        m_iter = 0;
        m_run  = 0;
        m_conv = 0;
        m_tout = 0;
        m_max  = 0;
    endtask

    task automatic modelFrame(input int l0, input int l1, input int l2, input int l3,
                              input int thr, input int mi);
        int m;
        m = absInt(l0);
        if (absInt(l1) > m) m = absInt(l1);
        if (absInt(l2) > m) m = absInt(l2);
        if (absInt(l3) > m) m = absInt(l3);
        m_max = m;
        if (m_iter < 65535) m_iter = m_iter + 1;
        if (m <= thr) begin
            if (m_run < 2) m_run = m_run + 1;
        end else begin
            m_run = 0;
        end
        if (m_conv == 0 && m_tout == 0) begin
            if (m_run == 2) m_conv = 1;
            else if (mi != 0 && m_iter == mi) m_tout = 1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_max_abs"}, max_abs, 0);
        checkOutput({tag, "_iter"}, iter_count, 0);
        checkOutput({tag, "_conv"}, converged, 0);
        checkOutput({tag, "_tout"}, timeout, 0);
    endtask

    // Sends one frame starting now (just after a clock edge). With abort_at != 0 it returns
    // at that bit index without driving it, so the caller can restart or reset mid-frame.
    task automatic applyStimulus(input int l0, input int l1, input int l2, input int l3,
                                 input int abort_at);
        logic [3:0][8:0] bits;
        int early;
        bits[0] = 9'(l0);
        bits[1] = 9'(l1);
        bits[2] = 9'(l2);
        bits[3] = 9'(l3);
        early = 0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) residue_in[i] = bits[i][0];
        for (int j = 1; j <= 9; j++) begin
            @(posedge clka);
            #1;
            if (abort_at != 0 && j == abort_at) return;
            start = 1'b0;
            if (frame_done) early++;
            if (j <= 8) begin
                for (int i = 0; i < 4; i++) residue_in[i] = bits[i][j];
            end else begin
                residue_in = '0;
            end
        end
        @(posedge clka);
        #1;
        modelFrame(l0, l1, l2, l3, int'(threshold), int'(max_iter));
        checkOutput("early_done", early, 0);
        checkOutput("frame_done", frame_done, 1);
        checkOutput("max_abs", max_abs, m_max);
        checkOutput("iter_count", iter_count, m_iter);
        checkOutput("converged", converged, m_conv);
        checkOutput("timeout", timeout, m_tout);
    endtask

    // Clear asserted together with start: clear must win and no frame may follow.
    task automatic doClear();
        int stray;
        clear = 1'b1;
        start = 1'b1;
        @(posedge clka);
        #1;
        clear = 1'b0;
        start = 1'b0;
        resetModel();
        checkAllZero("clear");
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clka);
            #1;
            if (frame_done) stray++;
        end
        checkOutput("clear_no_frame", stray, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        residue_in = '0;
        threshold  = '0;
        max_iter   = '0;

        #12;
        checkAllZero("reset");
        @(posedge clka);
        #1;
        rst_n = 1'b1;
        @(posedge clka);
        #1;

        vecs[0] = '{l0: 3,    l1: -5,   l2: 2,    l3: 0,   thr: 4,   exp_max: 5};
        vecs[1] = '{l0: -256, l1: 0,    l2: 0,    l3: 0,   thr: 300, exp_max: 256};
        vecs[2] = '{l0: 255,  l1: -255, l2: 0,    l3: 7,   thr: 254, exp_max: 255};
        vecs[3] = '{l0: 0,    l1: 0,    l2: 0,    l3: 0,   thr: 0,   exp_max: 0};
        vecs[4] = '{l0: -1,   l1: 1,    l2: -128, l3: 127, thr: 128, exp_max: 128};
        vecs[5] = '{l0: 100,  l1: -200, l2: 50,   l3: 0,   thr: 0,   exp_max: 200};

        for (int i = 0; i < 6; i++) begin
            threshold = 9'(vecs[i].thr);
            applyStimulus(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3, 0);
            checkOutput($sformatf("vec%0d_max", i), max_abs, vecs[i].exp_max);
        end
        checkOutput("vec_conv_after_table", converged, 1);

        // Two passing frames in a row converge on the second.
        doClear();
        threshold = 9'd3;
        applyStimulus(1, -2, 0, 3, 0);
        checkOutput("conv_first_frame", converged, 0);
        applyStimulus(1, -2, 0, 3, 0);
        checkOutput("conv_second_frame", converged, 1);
        checkOutput("conv_iter", iter_count, 2);

        // Iteration budget of three with every frame failing.
        doClear();
        max_iter  = 16'd3;
        threshold = 9'd10;
        for (int f = 0; f < 3; f++) applyStimulus(50, -50, 10, 0, 0);
        checkOutput("budget_timeout", timeout, 1);
        checkOutput("budget_conv", converged, 0);
        threshold = 9'd100;
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 0);
        checkOutput("budget_flags_frozen", converged, 0);
        checkOutput("budget_iter_continues", iter_count, 5);

        // Restart during the shift phase.
        doClear();
        max_iter  = '0;
        threshold = 9'd100;
        applyStimulus(9, 9, 9, 9, 4);
        applyStimulus(-7, 3, 1, 0, 0);
        checkOutput("restart_iter", iter_count, 1);
        checkOutput("restart_max", max_abs, 7);

        // Reset in the middle of a frame.
        applyStimulus(20, 0, 0, 0, 5);
        rst_n      = 1'b0;
        residue_in = '0;
        #2;
        checkAllZero("midreset");
        @(posedge clka);
        #1;
        checkOutput("midreset_hold_done", frame_done, 0);
        @(posedge clka);
        #1;
        rst_n = 1'b1;
        resetModel();
        @(posedge clka);
        #1;
        applyStimulus(-9, 4, 0, 0, 0);
        checkOutput("postreset_max", max_abs, 9);
        checkOutput("postreset_iter", iter_count, 1);

        // Random frames with occasional clears and small budgets.
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) begin
                doClear();
                max_iter = 16'($urandom_range(0, 6));
            end
            threshold = 9'($urandom_range(0, 300));
            applyStimulus(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                          int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/residue_monitor.md
RESIDUE_MONITOR -- requirements
Module: residue_monitor

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of PE residue streams monitored in parallel.
REQ-002 SHALL have parameter RES_W, default 9, bits per serial residue frame, two's complement, LSB first.
REQ-003 SHALL have parameter CONV_RUNS, default 2, consecutive passing frames required for convergence.
REQ-004 SHALL have parameter ITER_W, default 16, width of the iteration counter.
REQ-005 SHALL have port clka, input, 1, sole clock (one clock; all state on posedge clka).
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, synchronous clear of counters and sticky flags.
REQ-008 SHALL have port start, input, 1, frame start; residue_in carries bit 0 in the same cycle.
REQ-009 SHALL have port residue_in, input, NUM_LANES, one serial residue bit per lane.
REQ-010 SHALL have port threshold, input, RES_W, unsigned pass limit, sampled in the EVAL cycle.
REQ-011 SHALL have port max_iter, input, ITER_W, iteration budget; 0 disables timeout.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse when frame results update.
REQ-013 SHALL have port max_abs, output, RES_W, unsigned max |residue| over lanes, last frame.
REQ-014 SHALL have port iter_count, output, ITER_W, completed frames since reset/clear.
REQ-015 SHALL have port converged, output, 1, sticky convergence flag.
REQ-016 SHALL have port timeout, output, 1, sticky budget-exhausted flag.

Function
REQ-017 SHALL implement FSM IDLE -> SHIFT -> EVAL -> IDLE.
REQ-018 IDLE: start=1 -> SHIFT, bit counter 1, lane bit 0 captured.
REQ-019 SHIFT: capture one bit per lane per cycle, LSB-first; after bit RES_W-1 -> EVAL.
REQ-020 start=1 during SHIFT SHALL abort the frame and restart at bit 0 (counts as a new frame, old bits discarded, iter_count unchanged).
REQ-021 start during EVAL SHALL be ignored; start in the frame_done cycle (IDLE) SHALL be accepted.
REQ-022 EVAL: abs per lane as RES_W-bit unsigned (-2^(RES_W-1) -> 2^(RES_W-1), no saturation); max over lanes registered to max_abs.
REQ-023 Latency: start at cycle t -> frame_done high in cycle t+RES_W+1 only, outputs updated that cycle.
REQ-024 Pass = max_abs <= threshold; pass increments run counter (saturating at CONV_RUNS), fail clears it.
REQ-025 converged SHALL set when run counter reaches CONV_RUNS; stays set until clear or reset.
REQ-026 iter_count SHALL increment per completed frame, saturating at all-ones.
REQ-027 timeout SHALL set when max_iter!=0, iter_count (post-increment) == max_iter and converged not set in the same update; sticky.
REQ-028 Once converged or timeout, further frames SHALL still update max_abs/iter_count; flags unchanged.
REQ-029 clear SHALL zero iter_count, run counter, converged, timeout, max_abs, return FSM to IDLE; clear wins over simultaneous start.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, frame_done 0, max_abs 0, iter_count 0, converged 0, timeout 0, shift registers 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; first start after release begins a clean frame.

Structure
REQ-032 Shared package SHALL hold FSM state typedef and default constants RES_W, NUM_LANES, CONV_RUNS, ITER_W.
REQ-033 SHALL instantiate one sub-module res_deser (per-lane RES_W-bit LSB-first shift register plus abs) NUM_LANES times.

Verification
REQ-034 Lanes {+3,-5,+2,0}, threshold 4 -> max_abs 5, frame_done at t+10, run counter 0, converged 0.
REQ-035 Two frames lanes {1,-2,0,3}, threshold 3 -> converged rises in second frame_done cycle, iter_count 2.
REQ-036 Lane0 = -256, others 0 -> max_abs 256 (9'h100).
REQ-037 max_iter 3, all frames max 50, threshold 10 -> timeout set at third frame_done, converged 0.
REQ-038 start re-asserted at bit 4 of a frame -> no frame_done at t+10, frame_done at t'+10, iter_count +1 only.
REQ-039 rst_n low at bit 5, then new frame -> all outputs 0 during reset, clean result from the new frame.
